// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: 4x4 keypad scanner with debounce, ghost rejection and a one-entry valid/ack code buffer
module keypad_scan_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DEB   = 2'd1;
  localparam logic [1:0] S_PRESS = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;
  logic [3:0]    row_s1, row_s2;
  logic [SW-1:0] slot;
  logic [1:0]    col;
  logic [15:0]   map_q, map;
  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]    cand, cand_nx, k;
  logic          last, sweep_end, single, same, done, emit;
  assign col_out   = ~(4'b0001 << col);
  assign last      = slot == SW'(SCAN_DIV - 1);
  assign sweep_end = last && col == 2'd3;
  assign single    = map != 16'd0 && (map & (map - 16'd1)) == 16'd0;
  assign same      = single && k == cand;
  assign cnt_inc   = cnt + 1'b1;
  assign done      = cnt_inc == CW'(DEBOUNCE);
  assign emit      = sweep_end && state == S_DEB && same && done;
  // Pressed map for this sweep: live rows for the driven column, stored samples elsewhere; bit index = {row, col}
  always_comb begin
    map = map_q;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        map[r*4+c] = (2'(c) == col) ? ~row_s2[r] : map_q[r*4+c];
  end
  // Index of the set bit; only meaningful when exactly one key is pressed
  always_comb begin
    k = 4'd0;
    for (int i = 0; i < 16; i++)
      if (map[i]) k = 4'(i);
  end
  // Debounce FSM next state, evaluated only at sweep end
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    if (sweep_end)
      case (state)
        S_IDLE: if (single) begin
          state_nx = S_DEB;
          cand_nx  = k;
          cnt_nx   = CW'(1);
        end
        S_DEB: if (same) begin
          cnt_nx   = cnt_inc;
          state_nx = done ? S_PRESS : S_DEB;
        end else if (single) begin
          cand_nx = k;
          cnt_nx  = CW'(1);
        end else state_nx = S_IDLE;
        S_PRESS: if (!single) begin
          state_nx = S_REL;
          cnt_nx   = CW'(1);
        end
        default: if (!single) begin
          cnt_nx   = cnt_inc;
          state_nx = done ? S_IDLE : S_REL;
        end else state_nx = S_PRESS;
      endcase
  end
  // Row synchroniser, column scan and per-slot row sampling
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
      slot   <= '0;
      col    <= 2'd0;
      map_q  <= 16'd0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      slot   <= last ? '0 : slot + 1'b1;
      col    <= last ? col + 2'd1 : col;
      if (last) map_q <= map;
    end
  // FSM state and key_down; key_down tracks the held states of the next state
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state    <= S_IDLE;
      cand     <= 4'd0;
      cnt      <= '0;
      key_down <= 1'b0;
    end else begin
      state    <= state_nx;
      cand     <= cand_nx;
      cnt      <= cnt_nx;
      key_down <= state_nx[1];
    end
  // One-entry output buffer; an emit into a full, unacknowledged buffer is dropped and flagged
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (emit && key_valid && !key_ack) overrun <= 1'b1;
      else if (key_valid && key_ack) overrun <= 1'b0;
      if (emit && (!key_valid || key_ack)) begin
        key_code  <= cand;
        key_valid <= 1'b1;
      end else if (key_valid && key_ack) key_valid <= 1'b0;
    end
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder: scoreboard bench for keypad_scan_encoder with a behavioural keypad
module tb_keypad_scan_encoder;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  logic clk = 1'b0, nreset = 1'b0, key_ack = 1'b0;
  logic [3:0] row_in, col_out, key_code;
  logic key_valid, key_down, overrun;
  logic [15:0] keys = 16'h0;
  logic [3:0] exp_q[$];
  logic pv = 1'b0;
  logic [3:0] pc = 4'h0;
  int n_chk = 0, n_fail = 0;
  keypad_scan_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .nreset(nreset), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_down(key_down), .overrun(overrun)
  );
  always #5 clk = ~clk;
  // Keypad: a held key {row, col} pulls its row low while its column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end
  // Monitor: every newly presented code is popped against the scoreboard
  always @(negedge clk) begin
    if (key_valid && (!pv || key_code != pc)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL emit: key_code=%h presented, none expected", key_code);
      end else begin
        if (key_code !== exp_q[0]) begin
          n_fail++;
          $display("FAIL emit: key_code=%h expected %h", key_code, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    pv <= key_valid;
    pc <= key_code;
  end
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_col"}, col_out, 4'b1110);
    chk({tag, "_code"}, key_code, 4'h0);
    chk({tag, "_valid"}, {3'b0, key_valid}, 4'h0);
    chk({tag, "_down"}, {3'b0, key_down}, 4'h0);
    chk({tag, "_ovr"}, {3'b0, overrun}, 4'h0);
  endtask
  // Returns at the falling edge inside the last cycle of a sweep
  task automatic wait_sweep_end();
    int n = 0;
    @(negedge clk);
    while (col_out == 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (col_out != 4'b0111 && n < 100) begin @(negedge clk); n++; end
    repeat (SCAN_DIV - 1) @(negedge clk);
    if (n >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL sweep_timeout: col_out=%b", col_out);
    end
  endtask
  task automatic sweeps(input int n);
    repeat (n) wait_sweep_end();
  endtask
  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask
  logic [3:0] cols [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  initial begin
    #12;
    chk_reset("rst");
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("scan_col", col_out, cols[i % 4]);
      repeat (SCAN_DIV) @(negedge clk);
    end
    // Single key 9 (row2/col1) held 5 sweeps, released 4
    wait_sweep_end();
    keys = 16'h1 << 9;
    sweeps(2);
    wait_sweep_end();
    chk("pre_emit_valid", {3'b0, key_valid}, 4'h0);
    exp_q.push_back(4'h9);
    @(negedge clk);
    chk("press_valid", {3'b0, key_valid}, 4'h1);
    chk("press_down", {3'b0, key_down}, 4'h1);
    sweeps(2);
    keys = 16'h0;
    sweeps(2);
    chk("rel2_down", {3'b0, key_down}, 4'h1);
    wait_sweep_end();
    @(negedge clk);
    chk("rel3_down", {3'b0, key_down}, 4'h0);
    wait_sweep_end();
    chk("held_code", key_code, 4'h9);
    ack_pulse();
    chk("ack_valid", {3'b0, key_valid}, 4'h0);
    // Bounce: alternate press/release each sweep
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h1 << 9 : 16'h0;
      wait_sweep_end();
      @(negedge clk);
      chk("bounce_down", {3'b0, key_down}, 4'h0);
      chk("bounce_valid", {3'b0, key_valid}, 4'h0);
    end
    keys = 16'h0;
    // Ghost: two rows on column 3
    wait_sweep_end();
    keys = 16'h0088;
    sweeps(5);
    @(negedge clk);
    chk("ghost_down", {3'b0, key_down}, 4'h0);
    chk("ghost_valid", {3'b0, key_valid}, 4'h0);
    keys = 16'h0;
    // Overrun: 9 emitted and never acked, then F dropped
    wait_sweep_end();
    keys = 16'h1 << 9;
    sweeps(2);
    wait_sweep_end();
    exp_q.push_back(4'h9);
    keys = 16'h0;
    sweeps(3);
    keys = 16'h8000;
    sweeps(3);
    keys = 16'h0;
    @(negedge clk);
    chk("ovr_flag", {3'b0, overrun}, 4'h1);
    chk("ovr_code", key_code, 4'h9);
    chk("ovr_valid", {3'b0, key_valid}, 4'h1);
    sweeps(3);
    ack_pulse();
    chk("ovr_ack_valid", {3'b0, key_valid}, 4'h0);
    chk("ovr_ack_flag", {3'b0, overrun}, 4'h0);
    // Ack coinciding with a new emit reloads the buffer
    wait_sweep_end();
    keys = 16'h1 << 9;
    sweeps(2);
    wait_sweep_end();
    exp_q.push_back(4'h9);
    keys = 16'h0;
    sweeps(3);
    keys = 16'h8000;
    sweeps(2);
    wait_sweep_end();
    key_ack = 1'b1;
    exp_q.push_back(4'hF);
    keys = 16'h0;
    @(negedge clk);
    key_ack = 1'b0;
    chk("reload_valid", {3'b0, key_valid}, 4'h1);
    chk("reload_ovr", {3'b0, overrun}, 4'h0);
    chk("reload_code", key_code, 4'hF);
    sweeps(3);
    // Reset in the middle of debouncing a new key
    keys = 16'h1 << 9;
    wait_sweep_end();
    repeat (5) @(negedge clk);
    nreset = 1'b0;
    keys = 16'h0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    nreset = 1'b1;
    sweeps(5);
    chk("post_rst_valid", {3'b0, key_valid}, 4'h0);
    chk("post_rst_down", {3'b0, key_down}, 4'h0);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d codes never presented", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
